time_set_ctrl: RTL and testbench
================================

TIME_SET_CTRL -- requirements
Module: time_set_ctrl

Interface
REQ-001 SHALL have parameter BLINK_DIV, default 12_500_000, meaning CLK cycles per blink half-period.
REQ-002 SHALL have parameter TIMEOUT_S, default 10, meaning TICK_1HZ pulses of inactivity before auto-return (used only with REQ-030).
REQ-003 SHALL have port CLK, input, 1, the single clock.
REQ-004 SHALL have port RST, input, 1, reset, asynchronous and active-low.
REQ-005 SHALL have port TICK_1HZ, input, 1, one-CLK-cycle pulse once per second.
REQ-006 SHALL have ports BTN_MODE and BTN_INC, input, 1 each, debounced, synchronous, active-high levels.
REQ-007 SHALL have ports CUR_HOUR, CUR_MIN and CUR_SEC, input, 8 each, live BCD time from the time counter.
REQ-008 SHALL have port RUN_EN, output, 1, counter enable (0 while editing).
REQ-009 SHALL have port LOAD, output, 1, one-cycle load strobe to the time counter.
REQ-010 SHALL have ports LD_HOUR, LD_MIN and LD_SEC, output, 8 each, BCD values qualified by LOAD.
REQ-011 SHALL have ports DISP_HOUR, DISP_MIN and DISP_SEC, output, 8 each, BCD values for the display digits.
REQ-012 SHALL have port DIG_BLANK, output, 8, digit i blanked when bit i is 1.
REQ-013 SHALL have port MODE, output, 2, current state encoding.

Function
REQ-014 SHALL detect a press as BTN high with its previous-cycle sample low; the state and edit registers update on that same edge, so outputs change 1 cycle after BTN is first sampled high.
REQ-015 SHALL implement states RUN=0, SET_H=1, SET_M=2 and SET_S=3.
REQ-016 SHALL advance on a MODE press: RUN->SET_H->SET_M->SET_S->RUN.
REQ-017 SHALL, on RUN->SET_H, snapshot CUR_* into the edit registers and drive RUN_EN=0 from the next cycle.
REQ-018 SHALL, on SET_S->RUN, assert LOAD for exactly one cycle with LD_* equal to the edit registers; RUN_EN returns to 1 in the cycle after LOAD.
REQ-019 SHALL, on an INC press in SET_H, SET_M or SET_S, BCD-increment the selected field: hour 00..23 wraps to 00; min and sec 00..59 wrap to 00.
REQ-020 SHALL set the field to 00 on INC when the field is greater than or equal to its maximum or is non-BCD (for example 8'h25 hour or 8'h5A).
REQ-021 SHALL ignore an INC press in RUN.
REQ-022 SHALL act on MODE only when MODE and INC presses occur in the same cycle; INC is discarded.
REQ-023 SHALL drive DISP_* = CUR_* in RUN and DISP_* = the edit registers in SET_* states and during the LOAD cycle.
REQ-024 SHALL toggle the blink phase every BLINK_DIV cycles while in SET_* and hold the phase at 0 in RUN.
REQ-025 SHALL blank the digits of the edited field (SET_H bits 1:0, SET_M bits 4:3, SET_S bits 7:6) when the phase is 1; all other bits are 0.
REQ-026 SHALL reset the blink counter and phase to 0 on any INC press so the new value is visible at once.
REQ-027 SHALL keep LOAD at 0 in every cycle other than the SET_S->RUN transition.

Reset
REQ-028 SHALL, while RST is low, drive state RUN, RUN_EN=1, LOAD=0, edit registers 8'h00, DIG_BLANK=0, blink counter and phase 0, and button history 0.
REQ-029 SHALL discard the edits when reset occurs mid-edit: no LOAD is issued, and RUN_EN=1 is driven immediately.

Configuration
REQ-030 SHALL, with TIME_SET_AUTORET_EN defined, count TICK_1HZ in SET_* states, clear the count on any press, and go to RUN with RUN_EN=1 and no LOAD when the count reaches TIMEOUT_S, discarding the edits.
REQ-031 SHALL, without TIME_SET_AUTORET_EN, remain in SET_* indefinitely; TICK_1HZ is unused and has no counter logic.

Structure
REQ-032 SHALL take the state encoding, HOUR_MAX=8'h23, MS_MAX=8'h59 and the digit index constants from shared package time_pkg.
REQ-033 SHALL place the BCD increment-with-wrap in combinational sub-module bcd_inc (inputs value and max; output next value), instantiated once, with its max selected by state.

Verification
REQ-034 SHALL cover: CUR=12:34:56, MODE -> MODE=1, RUN_EN=0, DISP=12:34:56, DIG_BLANK toggling 8'h03 and 8'h00.
REQ-035 SHALL cover: edit hour 23 with INC -> 00; edit min 59 with INC -> 00; edit hour 8'h25 with INC -> 00.
REQ-036 SHALL cover: edit to 07:15:00, MODE x3 -> one LOAD cycle with LD=07:15:00, then RUN_EN=1 and MODE=0.
REQ-037 SHALL cover: MODE and INC rising in the same cycle in SET_M -> state SET_S, min unchanged.
REQ-038 SHALL cover: RST low in SET_M -> MODE=0, RUN_EN=1, LOAD never asserted.
REQ-039 SHALL cover, with TIME_SET_AUTORET_EN and TIMEOUT_S=3: SET_H plus 3 ticks without a press -> RUN, no LOAD; a press at tick 2 restarts the count.

Source files
------------

// File: rtl/time_pkg.sv
// rtl/time_pkg.sv - shared states, BCD limits and digit indices for the time-set controller
// Purpose: state encoding, field maxima and display digit positions shared by
//          time_set_ctrl and its testbench.
// Ports:   none (package)
package time_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    SET_H = 2'd1,
    SET_M = 2'd2,
    SET_S = 2'd3
  } state_t;

  localparam logic [7:0] HOUR_MAX = 8'h23;
  localparam logic [7:0] MS_MAX   = 8'h59;

  // Display digit positions; bits 2 and 5 are the separators.
  localparam int DIG_H_LO = 0;
  localparam int DIG_H_HI = 1;
  localparam int DIG_M_LO = 3;
  localparam int DIG_M_HI = 4;
  localparam int DIG_S_LO = 6;
  localparam int DIG_S_HI = 7;

  // Digits belonging to the field edited in a given state.
  function automatic logic [7:0] field_mask(input state_t st);
    logic [7:0] m;
    m = 8'h00;
    case (st)
      SET_H: begin m[DIG_H_LO] = 1'b1; m[DIG_H_HI] = 1'b1; end
      SET_M: begin m[DIG_M_LO] = 1'b1; m[DIG_M_HI] = 1'b1; end
      SET_S: begin m[DIG_S_LO] = 1'b1; m[DIG_S_HI] = 1'b1; end
      default: m = 8'h00;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/bcd_inc.sv
// rtl/bcd_inc.sv - combinational two-digit BCD increment with wrap to 00
// Purpose: next BCD value of a field; wraps to 00 at or above max and on any
//          non-BCD input so a corrupt snapshot recovers on the first press.
// Ports:   value    - current BCD field
//          max      - largest legal value of the field
//          next_val - incremented value
module bcd_inc (
  input  logic [7:0] value,
  input  logic [7:0] max,
  output logic [7:0] next_val
);

  logic bad;

  always_comb begin
    bad = (value >= max) || (value[3:0] > 4'd9) || (value[7:4] > 4'd9);
    if (bad) begin
      next_val = 8'h00;
    end else if (value[3:0] == 4'd9) begin
      next_val = {value[7:4] + 4'd1, 4'h0};
    end else begin
      next_val = {value[7:4], value[3:0] + 4'd1};
    end
  end

endmodule

// File: rtl/time_set_ctrl.sv
// rtl/time_set_ctrl.sv - clock time-setting controller (mode/inc buttons, blink, load)
// Purpose: RUN -> SET_H -> SET_M -> SET_S -> RUN editor for a BCD clock.
//          Optional macro TIME_SET_AUTORET_EN: return to RUN without loading
//          after TIMEOUT_S seconds without a button press.
// Ports:   CLK, RST (async active-low), TICK_1HZ (1 s pulse),
//          BTN_MODE, BTN_INC (debounced levels), CUR_HOUR/MIN/SEC (live BCD),
//          RUN_EN (counter enable), LOAD + LD_HOUR/MIN/SEC (load strobe/data),
//          DISP_HOUR/MIN/SEC (display BCD), DIG_BLANK (per-digit blank),
//          MODE (state encoding)
module time_set_ctrl
  import time_pkg::*;
#(
  parameter int BLINK_DIV = 12_500_000,
  parameter int TIMEOUT_S = 10
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       TICK_1HZ,
  input  logic       BTN_MODE,
  input  logic       BTN_INC,
  input  logic [7:0] CUR_HOUR,
  input  logic [7:0] CUR_MIN,
  input  logic [7:0] CUR_SEC,
  output logic       RUN_EN,
  output logic       LOAD,
  output logic [7:0] LD_HOUR,
  output logic [7:0] LD_MIN,
  output logic [7:0] LD_SEC,
  output logic [7:0] DISP_HOUR,
  output logic [7:0] DISP_MIN,
  output logic [7:0] DISP_SEC,
  output logic [7:0] DIG_BLANK,
  output logic [1:0] MODE
);

  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

  state_t        state_q, state_d;
  logic          btn_mode_q, btn_inc_q;
  logic [7:0]    hour_q, min_q, sec_q;
  logic [7:0]    hour_d, min_d, sec_d;
  logic          run_en_q, run_en_d;
  logic          load_q, load_d;
  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic          phase_q, phase_d;

  logic          mode_press, inc_rise, inc_press;
  logic [7:0]    inc_in, inc_max, inc_out;
  logic          timeout;

  assign mode_press = BTN_MODE & ~btn_mode_q;
  assign inc_rise   = BTN_INC & ~btn_inc_q;
  // MODE wins a simultaneous press; the INC is dropped.
  assign inc_press  = inc_rise & ~mode_press;

  always_comb begin
    case (state_q)
      SET_M:   begin inc_in = min_q;  inc_max = MS_MAX;   end
      SET_S:   begin inc_in = sec_q;  inc_max = MS_MAX;   end
      default: begin inc_in = hour_q; inc_max = HOUR_MAX; end
    endcase
  end

  bcd_inc u_bcd_inc (
    .value    (inc_in),
    .max      (inc_max),
    .next_val (inc_out)
  );

`ifdef TIME_SET_AUTORET_EN
  localparam int TW = (TIMEOUT_S > 1) ? $clog2(TIMEOUT_S + 1) : 1;
  logic [TW-1:0] tick_cnt_q;

  // The tick that would make the count reach TIMEOUT_S is the timeout itself.
  assign timeout = TICK_1HZ && (state_q != RUN) && !(mode_press || inc_rise) &&
                   (tick_cnt_q == TW'(TIMEOUT_S - 1));

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      tick_cnt_q <= '0;
    end else if ((state_q == RUN) || mode_press || inc_rise || timeout) begin
      tick_cnt_q <= '0;
    end else if (TICK_1HZ) begin
      tick_cnt_q <= tick_cnt_q + 1'b1;
    end
  end
`else
  logic unused_tick;
  assign unused_tick = TICK_1HZ;
  assign timeout     = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    hour_d   = hour_q;
    min_d    = min_q;
    sec_d    = sec_q;
    run_en_d = run_en_q;
    load_d   = 1'b0;

    // Counter is re-enabled the cycle after it has been loaded.
    if (load_q) run_en_d = 1'b1;

    case (state_q)
      RUN: begin
        if (mode_press) begin
          state_d  = SET_H;
          hour_d   = CUR_HOUR;
          min_d    = CUR_MIN;
          sec_d    = CUR_SEC;
          run_en_d = 1'b0;
        end
      end
      SET_H: begin
        if (mode_press)     state_d = SET_M;
        else if (inc_press) hour_d  = inc_out;
      end
      SET_M: begin
        if (mode_press)     state_d = SET_S;
        else if (inc_press) min_d   = inc_out;
      end
      SET_S: begin
        if (mode_press) begin
          state_d = RUN;
          load_d  = 1'b1;
        end else if (inc_press) begin
          sec_d = inc_out;
        end
      end
      default: state_d = RUN;
    endcase

    if (timeout) begin
      state_d  = RUN;
      run_en_d = 1'b1;
      load_d   = 1'b0;
    end
  end

  // Blink restarts on entry and on every INC so the new value shows at once.
  always_comb begin
    blink_cnt_d = blink_cnt_q;
    phase_d     = phase_q;
    if ((state_q == RUN) || (state_d == RUN) || inc_press) begin
      blink_cnt_d = '0;
      phase_d     = 1'b0;
    end else if (blink_cnt_q == BLINK_LAST) begin
      blink_cnt_d = '0;
      phase_d     = ~phase_q;
    end else begin
      blink_cnt_d = blink_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q     <= RUN;
      btn_mode_q  <= 1'b0;
      btn_inc_q   <= 1'b0;
      hour_q      <= 8'h00;
      min_q       <= 8'h00;
      sec_q       <= 8'h00;
      run_en_q    <= 1'b1;
      load_q      <= 1'b0;
      blink_cnt_q <= '0;
      phase_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      btn_mode_q  <= BTN_MODE;
      btn_inc_q   <= BTN_INC;
      hour_q      <= hour_d;
      min_q       <= min_d;
      sec_q       <= sec_d;
      run_en_q    <= run_en_d;
      load_q      <= load_d;
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
    end
  end

  logic show_edit;
  assign show_edit = (state_q != RUN) || load_q;

  assign MODE      = state_q;
  assign RUN_EN    = run_en_q;
  assign LOAD      = load_q;
  assign LD_HOUR   = hour_q;
  assign LD_MIN    = min_q;
  assign LD_SEC    = sec_q;
  assign DISP_HOUR = show_edit ? hour_q : CUR_HOUR;
  assign DISP_MIN  = show_edit ? min_q  : CUR_MIN;
  assign DISP_SEC  = show_edit ? sec_q  : CUR_SEC;
  assign DIG_BLANK = phase_q ? field_mask(state_q) : 8'h00;

endmodule

// File: tb/tb_time_set_ctrl.sv
// tb/tb_time_set_ctrl.sv - directed self-checking bench for time_set_ctrl
module tb_time_set_ctrl;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       TICK_1HZ = 1'b0;
  logic       BTN_MODE = 1'b0;
  logic       BTN_INC = 1'b0;
  logic [7:0] CUR_HOUR = 8'h12;
  logic [7:0] CUR_MIN = 8'h34;
  logic [7:0] CUR_SEC = 8'h56;
  logic       RUN_EN, LOAD;
  logic [7:0] LD_HOUR, LD_MIN, LD_SEC;
  logic [7:0] DISP_HOUR, DISP_MIN, DISP_SEC;
  logic [7:0] DIG_BLANK;
  logic [1:0] MODE;

  int n_checks = 0;
  int n_fail   = 0;
  int load_cnt = 0;

  time_set_ctrl #(.BLINK_DIV(4), .TIMEOUT_S(3)) dut (
    .CLK(CLK), .RST(RST), .TICK_1HZ(TICK_1HZ),
    .BTN_MODE(BTN_MODE), .BTN_INC(BTN_INC),
    .CUR_HOUR(CUR_HOUR), .CUR_MIN(CUR_MIN), .CUR_SEC(CUR_SEC),
    .RUN_EN(RUN_EN), .LOAD(LOAD),
    .LD_HOUR(LD_HOUR), .LD_MIN(LD_MIN), .LD_SEC(LD_SEC),
    .DISP_HOUR(DISP_HOUR), .DISP_MIN(DISP_MIN), .DISP_SEC(DISP_SEC),
    .DIG_BLANK(DIG_BLANK), .MODE(MODE)
  );

  always #5 CLK = ~CLK;

  always @(negedge CLK) if (LOAD) load_cnt++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic press(input logic m, input logic i);
    @(negedge CLK); BTN_MODE = m; BTN_INC = i;
    @(negedge CLK); BTN_MODE = 1'b0; BTN_INC = 1'b0;
  endtask

  task automatic incs(input int n);
    for (int k = 0; k < n; k++) press(1'b0, 1'b1);
  endtask

  task automatic tick();
    @(negedge CLK); TICK_1HZ = 1'b1;
    @(negedge CLK); TICK_1HZ = 1'b0;
    repeat (2) @(negedge CLK);
  endtask

  function automatic logic [31:0] disp();
    return {8'h00, DISP_HOUR, DISP_MIN, DISP_SEC};
  endfunction

  initial begin
    #12;
    check("rst_mode",   32'(MODE), 32'd0);
    check("rst_run_en", 32'(RUN_EN), 32'd1);
    check("rst_load",   32'(LOAD), 32'd0);
    check("rst_blank",  32'(DIG_BLANK), 32'h00);
    check("rst_disp",   disp(), 32'h123456);
    @(negedge CLK); RST = 1'b1;
    repeat (2) @(negedge CLK);

    // Enter SET_H, snapshot and blink
    press(1'b1, 1'b0);
    check("seth_mode",   32'(MODE), 32'd1);
    check("seth_run_en", 32'(RUN_EN), 32'd0);
    check("seth_disp",   disp(), 32'h123456);
    check("blink_start", 32'(DIG_BLANK), 32'h00);
    repeat (3) @(negedge CLK);
    check("blink_pre",   32'(DIG_BLANK), 32'h00);
    @(negedge CLK);
    check("blink_on",    32'(DIG_BLANK), 32'h03);
    repeat (4) @(negedge CLK);
    check("blink_off",   32'(DIG_BLANK), 32'h00);
    CUR_HOUR = 8'h01; CUR_MIN = 8'h02; CUR_SEC = 8'h03;
    @(negedge CLK);
    check("edit_disp",   disp(), 32'h123456);

    // Hour 12 -> 23 -> 00 -> 07
    incs(11);
    check("hour_23",     32'(DISP_HOUR), 32'h23);
    check("inc_unblank", 32'(DIG_BLANK), 32'h00);
    incs(1);
    check("hour_wrap",   32'(DISP_HOUR), 32'h00);
    incs(7);
    check("hour_07",     32'(DISP_HOUR), 32'h07);

    // Minute 34 -> 59 -> 00 -> 15
    press(1'b1, 1'b0);
    check("setm_mode",   32'(MODE), 32'd2);
    incs(25);
    check("min_59",      32'(DISP_MIN), 32'h59);
    incs(1);
    check("min_wrap",    32'(DISP_MIN), 32'h00);
    incs(15);
    check("min_15",      32'(DISP_MIN), 32'h15);

    // Second 56 -> 00
    press(1'b1, 1'b0);
    check("sets_mode",   32'(MODE), 32'd3);
    incs(4);
    check("sec_00",      32'(DISP_SEC), 32'h00);

    // Commit
    CUR_HOUR = 8'h11; CUR_MIN = 8'h22; CUR_SEC = 8'h33;
    press(1'b1, 1'b0);
    check("load_pulse",  32'(LOAD), 32'd1);
    check("load_data",   {8'h00, LD_HOUR, LD_MIN, LD_SEC}, 32'h071500);
    check("load_mode",   32'(MODE), 32'd0);
    check("load_run_en", 32'(RUN_EN), 32'd0);
    check("load_disp",   disp(), 32'h071500);
    @(negedge CLK);
    check("post_load",   32'(LOAD), 32'd0);
    check("post_run_en", 32'(RUN_EN), 32'd1);
    check("post_disp",   disp(), 32'h112233);
    check("load_count1", 32'(load_cnt), 32'd1);

    // INC in RUN is ignored
    press(1'b0, 1'b1);
    check("runinc_mode", 32'(MODE), 32'd0);
    check("runinc_disp", disp(), 32'h112233);

    // Out-of-range / non-BCD snapshot, simultaneous press
    CUR_HOUR = 8'h25; CUR_MIN = 8'h59; CUR_SEC = 8'h5A;
    press(1'b1, 1'b0);
    check("snap_bad",    disp(), 32'h25595A);
    incs(1);
    check("hour25_wrap", 32'(DISP_HOUR), 32'h00);
    press(1'b1, 1'b0);
    press(1'b1, 1'b1);
    check("both_mode",   32'(MODE), 32'd3);
    check("both_min",    32'(DISP_MIN), 32'h59);
    incs(1);
    check("sec5a_wrap",  32'(DISP_SEC), 32'h00);
    press(1'b1, 1'b0);
    check("load2_data",  {8'h00, LD_HOUR, LD_MIN, LD_SEC}, 32'h005900);
    @(negedge CLK);
    check("load_count2", 32'(load_cnt), 32'd2);

    // Reset mid-edit
    press(1'b1, 1'b0);
    press(1'b1, 1'b0);
    check("pre_rst_mode", 32'(MODE), 32'd2);
    @(negedge CLK); RST = 1'b0;
    #1;
    check("midrst_mode",   32'(MODE), 32'd0);
    check("midrst_run_en", 32'(RUN_EN), 32'd1);
    check("midrst_load",   32'(LOAD), 32'd0);
    @(negedge CLK); RST = 1'b1;
    repeat (3) @(negedge CLK);
    check("midrst_count",  32'(load_cnt), 32'd2);

`ifdef TIME_SET_AUTORET_EN
    press(1'b1, 1'b0);
    tick(); tick();
    check("ar_hold2",    32'(MODE), 32'd1);
    tick();
    check("ar_mode",     32'(MODE), 32'd0);
    check("ar_run_en",   32'(RUN_EN), 32'd1);
    check("ar_disp",     disp(), {8'h00, CUR_HOUR, CUR_MIN, CUR_SEC});
    press(1'b1, 1'b0);
    tick(); tick();
    press(1'b0, 1'b1);
    tick(); tick();
    check("ar_restart",  32'(MODE), 32'd1);
    tick();
    check("ar_mode2",    32'(MODE), 32'd0);
    check("ar_nolod",    32'(load_cnt), 32'd2);
`else
    press(1'b1, 1'b0);
    for (int k = 0; k < 5; k++) tick();
    check("noar_mode",   32'(MODE), 32'd1);
    check("noar_run_en", 32'(RUN_EN), 32'd0);
    check("noar_nolod",  32'(load_cnt), 32'd2);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
